// File: rtl/fetch2_group_queue.sv
// rtl/fetch2_group_queue.sv - fetch2 group register, BTB alias check and instruction queue
//
// Purpose: holds one fetch group from fetch1, pairs it with icache data, predecodes the
// predicted slot to catch BTB aliases on non-branch instructions (redirect + BTB invalidate),
// and buffers correct-path instructions in a circular queue feeding decode one per cycle.
//
// Optional feature: define FETCH2_PERF_CNT_EN to enable the performance counters; when it is
// not defined the perf_* ports are present but tied to 0.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   flush                               pipeline flush (clears group reg and queue)
//   in_valid / in_rdy                   fetch1 group handshake
//   in_pc, in_slot_mask                 slot 0 pc, contiguous valid-slot mask
//   in_is_pred, in_pred_slot, in_btb_pre  BTB taken prediction and target
//   in_excp_valid, in_excp_ecode        fetch exception on the group
//   icache_data, icache_data_valid      instruction words for the held group
//   out_valid / out_rdy                 decode handshake
//   out_pc, out_inst, out_is_pred, out_btb_pre, out_excp_valid, out_excp_ecode  head entry
//   bp_error_flush, wr_pc_valid, wr_pc  mispredict pulse and redirect
//   btb_inv_valid, btb_inv_pc           BTB invalidate request
//   perf_bp_err_cnt, perf_full_cnt      performance counters

module fetch2_group_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8,
  localparam int PSW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int AW  = $clog2(QUEUE_DEPTH),
  localparam int CW  = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_rdy,
  input  logic [31:0]               in_pc,
  input  logic [FETCH_WIDTH-1:0]    in_slot_mask,
  input  logic                      in_is_pred,
  input  logic [PSW-1:0]            in_pred_slot,
  input  logic [31:0]               in_btb_pre,
  input  logic                      in_excp_valid,
  input  logic [5:0]                in_excp_ecode,
  input  logic [32*FETCH_WIDTH-1:0] icache_data,
  input  logic                      icache_data_valid,
  output logic                      out_valid,
  input  logic                      out_rdy,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_inst,
  output logic                      out_is_pred,
  output logic [31:0]               out_btb_pre,
  output logic                      out_excp_valid,
  output logic [5:0]                out_excp_ecode,
  output logic                      bp_error_flush,
  output logic                      wr_pc_valid,
  output logic [31:0]               wr_pc,
  output logic                      btb_inv_valid,
  output logic [31:0]               btb_inv_pc,
  output logic [31:0]               perf_bp_err_cnt,
  output logic [31:0]               perf_full_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_pred;
    logic [31:0] btb_pre;
    logic        excp_valid;
    logic [5:0]  excp_ecode;
  } entry_t;

  // Group register
  logic                   grp_valid_q, grp_valid_d;
  logic [31:0]            grp_pc_q;
  logic [FETCH_WIDTH-1:0] grp_mask_q;
  logic                   grp_is_pred_q;
  logic [PSW-1:0]         grp_pred_slot_q;
  logic [31:0]            grp_btb_pre_q;
  logic                   grp_excp_q;
  logic [5:0]             grp_ecode_q;

  // Queue storage and pointers (extra MSB is the wrap bit)
  entry_t                 mem_q [QUEUE_DEPTH];
  logic [CW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count, free, n_enq;
  logic                   empty, pop, accept, mispredict, pred_is_branch;
  logic [31:0]            pred_pc, pred_inst;
  logic [31:0]            slot_inst [FETCH_WIDTH];
  entry_t                 slot_entry [FETCH_WIDTH];
  logic [AW-1:0]          wr_idx [FETCH_WIDTH];
  entry_t                 head_entry;

  // Pointer difference gives occupancy; equal pointers = empty, MSB-only difference = full.
  assign count = tail_q - head_q;
  assign empty = (count == '0);
  assign free  = CW'(QUEUE_DEPTH) - count;

  always_comb begin
    n_enq     = '0;
    pred_inst = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_inst[i] = icache_data[32*i +: 32];
      if (PSW'(i) == grp_pred_slot_q) pred_inst = slot_inst[i];
    end
    if (grp_excp_q) begin
      n_enq = CW'(1);
    end else begin
      // Slots past the predicted-taken slot are wrong-path and never enqueued.
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (grp_mask_q[i] && (!grp_is_pred_q || (PSW'(i) <= grp_pred_slot_q)))
          n_enq = n_enq + CW'(1);
      end
    end
  end

  assign pred_pc        = grp_pc_q + (32'(grp_pred_slot_q) << 2);
  assign pred_is_branch = (pred_inst[31:26] >= 6'b010011) && (pred_inst[31:26] <= 6'b011011);

  assign accept     = grp_valid_q & ~flush & (icache_data_valid | grp_excp_q) & (free >= n_enq);
  assign mispredict = accept & grp_is_pred_q & ~grp_excp_q & ~pred_is_branch &
                      (grp_btb_pre_q != pred_pc + 32'd4);

  assign in_rdy         = ~grp_valid_q | accept;
  assign bp_error_flush = mispredict;
  assign wr_pc_valid    = mispredict;
  assign btb_inv_valid  = mispredict;
  assign wr_pc          = mispredict ? pred_pc + 32'd4 : '0;
  assign btb_inv_pc     = mispredict ? pred_pc : '0;

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i]                = tail_q[AW-1:0] + AW'(i);
      slot_entry[i].pc         = grp_pc_q + (32'(i) << 2);
      slot_entry[i].inst       = grp_excp_q ? 32'd0 : slot_inst[i];
      // A mispredicted alias slot is demoted to a plain fall-through instruction.
      slot_entry[i].is_pred    = grp_is_pred_q & ~grp_excp_q & ~mispredict &
                                 (PSW'(i) == grp_pred_slot_q);
      slot_entry[i].btb_pre    = grp_btb_pre_q;
      slot_entry[i].excp_valid = grp_excp_q;
      slot_entry[i].excp_ecode = grp_ecode_q;
    end
  end

  // A mispredicting accept drops whatever fetch1 offers this cycle (it is wrong-path).
  assign grp_valid_d = in_valid & ~mispredict;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_valid_q     <= 1'b0;
      grp_pc_q        <= '0;
      grp_mask_q      <= '0;
      grp_is_pred_q   <= 1'b0;
      grp_pred_slot_q <= '0;
      grp_btb_pre_q   <= '0;
      grp_excp_q      <= 1'b0;
      grp_ecode_q     <= '0;
    end else if (flush) begin
      grp_valid_q     <= 1'b0;
    end else if (in_rdy) begin
      grp_valid_q     <= grp_valid_d;
      grp_pc_q        <= in_pc;
      grp_mask_q      <= in_slot_mask;
      grp_is_pred_q   <= in_is_pred;
      grp_pred_slot_q <= in_pred_slot;
      grp_btb_pre_q   <= in_btb_pre;
      grp_excp_q      <= in_excp_valid;
      grp_ecode_q     <= in_excp_ecode;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (CW'(i) < n_enq) mem_q[wr_idx[i]] <= slot_entry[i];
      end
    end
  end

  assign pop    = ~empty & out_rdy & ~flush;
  assign head_d = flush ? '0 : head_q + CW'(pop);
  assign tail_d = flush ? '0 : tail_q + (accept ? n_enq : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_entry     = empty ? '0 : mem_q[head_q[AW-1:0]];
  assign out_valid      = ~empty;
  assign out_pc         = head_entry.pc;
  assign out_inst       = head_entry.inst;
  assign out_is_pred    = head_entry.is_pred;
  assign out_btb_pre    = head_entry.btb_pre;
  assign out_excp_valid = head_entry.excp_valid;
  assign out_excp_ecode = head_entry.excp_ecode;

`ifdef FETCH2_PERF_CNT_EN
  logic [31:0] perf_bp_err_cnt_q, perf_full_cnt_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_bp_err_cnt_q <= '0;
      perf_full_cnt_q   <= '0;
    end else begin
      if (mispredict) perf_bp_err_cnt_q <= perf_bp_err_cnt_q + 32'd1;
      if (grp_valid_q && (free < n_enq)) perf_full_cnt_q <= perf_full_cnt_q + 32'd1;
    end
  end

  assign perf_bp_err_cnt = perf_bp_err_cnt_q;
  assign perf_full_cnt   = perf_full_cnt_q;
`else
  assign perf_bp_err_cnt = '0;
  assign perf_full_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch2_group_queue.sv
// tb/tb_fetch2_group_queue.sv - scoreboard bench for fetch2_group_queue (FETCH_WIDTH=2, QUEUE_DEPTH=8)

module tb_fetch2_group_queue;

  localparam logic [31:0] ADDI = 32'h02800401;
  localparam logic [31:0] ADD  = 32'h00101c22;
  localparam logic [31:0] BEQ  = 32'h58000400;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_rdy;
  logic [31:0] in_pc, in_btb_pre;
  logic [1:0]  in_slot_mask;
  logic        in_is_pred;
  logic [0:0]  in_pred_slot;
  logic        in_excp_valid;
  logic [5:0]  in_excp_ecode;
  logic [63:0] icache_data;
  logic        icache_data_valid;
  logic        out_valid, out_rdy, out_is_pred, out_excp_valid;
  logic [31:0] out_pc, out_inst, out_btb_pre;
  logic [5:0]  out_excp_ecode;
  logic        bp_error_flush, wr_pc_valid, btb_inv_valid;
  logic [31:0] wr_pc, btb_inv_pc, perf_bp_err_cnt, perf_full_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_pred;
    logic [31:0] btb;
    logic        ex;
    logic [5:0]  ec;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch2_group_queue #(.FETCH_WIDTH(2), .QUEUE_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_rdy(in_rdy),
    .in_pc(in_pc), .in_slot_mask(in_slot_mask), .in_is_pred(in_is_pred),
    .in_pred_slot(in_pred_slot), .in_btb_pre(in_btb_pre), .in_excp_valid(in_excp_valid),
    .in_excp_ecode(in_excp_ecode), .icache_data(icache_data),
    .icache_data_valid(icache_data_valid), .out_valid(out_valid), .out_rdy(out_rdy),
    .out_pc(out_pc), .out_inst(out_inst), .out_is_pred(out_is_pred),
    .out_btb_pre(out_btb_pre), .out_excp_valid(out_excp_valid),
    .out_excp_ecode(out_excp_ecode), .bp_error_flush(bp_error_flush),
    .wr_pc_valid(wr_pc_valid), .wr_pc(wr_pc), .btb_inv_valid(btb_inv_valid),
    .btb_inv_pc(btb_inv_pc), .perf_bp_err_cnt(perf_bp_err_cnt), .perf_full_cnt(perf_full_cnt)
  );

  // Scoreboard consumer: every decode handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_rdy) begin
      exp_t e;
      n_vec = n_vec + 1;
      if (sb.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL pop_unexpected: got pc=%h inst=%h, required no entry", out_pc, out_inst);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_inst !== e.inst || out_is_pred !== e.is_pred ||
            out_excp_valid !== e.ex || out_excp_ecode !== e.ec ||
            (e.is_pred && out_btb_pre !== e.btb)) begin
          n_err = n_err + 1;
          $display("FAIL pop_entry: got pc=%h inst=%h pred=%b btb=%h ex=%b ec=%h, required pc=%h inst=%h pred=%b btb=%h ex=%b ec=%h",
                   out_pc, out_inst, out_is_pred, out_btb_pre, out_excp_valid, out_excp_ecode,
                   e.pc, e.inst, e.is_pred, e.btb, e.ex, e.ec);
        end
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pred,
                      input logic [31:0] btb, input logic ex, input logic [5:0] ec);
    exp_t e;
    e.pc = pc; e.inst = inst; e.is_pred = pred; e.btb = btb; e.ex = ex; e.ec = ec;
    sb.push_back(e);
  endtask

  // Presents a group and returns 1 ns after the edge that loads it into the group register.
  // icache data stays driven so the held group can be accepted.
  task automatic drive_group(input logic [31:0] pc, input logic [1:0] mask, input logic pred,
                             input logic slot, input logic [31:0] btb, input logic [31:0] i0,
                             input logic [31:0] i1, input logic ex, input logic [5:0] ec,
                             input logic dv);
    int t = 0;
    in_pc = pc; in_slot_mask = mask; in_is_pred = pred; in_pred_slot = slot;
    in_btb_pre = btb; in_excp_valid = ex; in_excp_ecode = ec;
    icache_data = {i1, i0}; icache_data_valid = dv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_rdy && t < 50) begin @(negedge clk); t++; end
    if (!in_rdy) begin
      n_vec = n_vec + 1; n_err = n_err + 1;
      $display("FAIL load_timeout: in_rdy=%b, required 1 within 50 cycles", in_rdy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_accept();
    int t = 0;
    @(negedge clk);
    while (!in_rdy && t < 50) begin @(negedge clk); t++; end
    if (!in_rdy) begin
      n_vec = n_vec + 1; n_err = n_err + 1;
      $display("FAIL accept_timeout: in_rdy=%b, required 1 within 50 cycles", in_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    out_rdy = 1'b1;
    @(negedge clk);
    while (out_valid && t < 100) begin @(negedge clk); t++; end
    n_vec = n_vec + 1;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: out_valid=%b pending=%0d, required 0 and 0", out_valid, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec = n_vec + 2;
    if (in_rdy !== 1'b1 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
      n_err = n_err + 1;
      $display("FAIL reset_handshake: in_rdy=%b out_valid=%b out_pc=%h, required 1 0 0", in_rdy, out_valid, out_pc);
    end
    if (bp_error_flush !== 1'b0 || wr_pc_valid !== 1'b0 || btb_inv_valid !== 1'b0 ||
        perf_bp_err_cnt !== 32'd0 || perf_full_cnt !== 32'd0) begin
      n_err = n_err + 1;
      $display("FAIL reset_side: bp=%b wr=%b inv=%b perf=%h/%h, required all 0",
               bp_error_flush, wr_pc_valid, btb_inv_valid, perf_bp_err_cnt, perf_full_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    out_rdy = 1'b1;
    push(32'h1c000000, ADDI, 1'b0, 32'd0, 1'b0, 6'd0);
    push(32'h1c000004, ADD,  1'b0, 32'd0, 1'b0, 6'd0);
    drive_group(32'h1c000000, 2'b11, 1'b0, 1'b0, 32'd0, ADDI, ADD, 1'b0, 6'd0, 1'b1);
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b0 || in_rdy !== 1'b1 || bp_error_flush !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL lat_accept: out_valid=%b in_rdy=%b bp=%b, required 0 1 0", out_valid, in_rdy, bp_error_flush);
    end
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b1 || out_pc !== 32'h1c000000) begin
      n_err = n_err + 1;
      $display("FAIL lat_n1: out_valid=%b pc=%h, required 1 1c000000", out_valid, out_pc);
    end
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b1 || out_pc !== 32'h1c000004) begin
      n_err = n_err + 1;
      $display("FAIL lat_n2: out_valid=%b pc=%h, required 1 1c000004", out_valid, out_pc);
    end
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL lat_empty: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mispredict();
    logic [31:0] pcs [2];
    logic        slots [2];
    pcs[0] = 32'h1c000000; pcs[1] = 32'h1c000020;
    slots[0] = 1'b0;       slots[1] = 1'b1;
    out_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ppc;
      ppc = pcs[k] + (slots[k] ? 32'd4 : 32'd0);
      push(pcs[k], ADDI, 1'b0, 32'd0, 1'b0, 6'd0);
      if (slots[k]) push(pcs[k] + 32'd4, ADDI, 1'b0, 32'd0, 1'b0, 6'd0);
      drive_group(pcs[k], 2'b11, 1'b1, slots[k], 32'h1c000100 + 32'(k) * 32'h100,
                  ADDI, ADDI, 1'b0, 6'd0, 1'b1);
      @(negedge clk);
      n_vec = n_vec + 1;
      if (bp_error_flush !== 1'b1 || wr_pc_valid !== 1'b1 || btb_inv_valid !== 1'b1 ||
          wr_pc !== ppc + 32'd4 || btb_inv_pc !== ppc) begin
        n_err = n_err + 1;
        $display("FAIL misp_pulse: bp=%b wr=%b/%h inv=%b/%h, required 1 1/%h 1/%h",
                 bp_error_flush, wr_pc_valid, wr_pc, btb_inv_valid, btb_inv_pc, ppc + 32'd4, ppc);
      end
      @(negedge clk);
      n_vec = n_vec + 1;
      if (bp_error_flush !== 1'b0 || out_valid !== 1'b1) begin
        n_err = n_err + 1;
        $display("FAIL misp_after: bp=%b out_valid=%b, required 0 1", bp_error_flush, out_valid);
      end
      @(posedge clk); #1;
      drain();
    end
  endtask

  task automatic test_pred_branch();
    out_rdy = 1'b1;
    push(32'h1c000000, BEQ, 1'b1, 32'h1c000100, 1'b0, 6'd0);
    drive_group(32'h1c000000, 2'b11, 1'b1, 1'b0, 32'h1c000100, BEQ, ADD, 1'b0, 6'd0, 1'b1);
    @(negedge clk);
    n_vec = n_vec + 1;
    if (bp_error_flush !== 1'b0 || wr_pc_valid !== 1'b0 || btb_inv_valid !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL branch_pulse: bp=%b wr=%b inv=%b, required 0 0 0", bp_error_flush, wr_pc_valid, btb_inv_valid);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL branch_slot1: out_valid=%b pc=%h, required 0 (slot 1 dropped)", out_valid, out_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    out_rdy = 1'b0;
    for (int g = 0; g < 5; g++) begin
      logic [31:0] pc;
      pc = 32'h1c001000 + 32'(g) * 32'd8;
      push(pc,          32'h02800000 + 32'(2*g),     1'b0, 32'd0, 1'b0, 6'd0);
      push(pc + 32'd4,  32'h02800000 + 32'(2*g + 1), 1'b0, 32'd0, 1'b0, 6'd0);
      drive_group(pc, 2'b11, 1'b0, 1'b0, 32'd0, 32'h02800000 + 32'(2*g),
                  32'h02800000 + 32'(2*g + 1), 1'b0, 6'd0, 1'b1);
      if (g < 4) wait_accept();
    end
    @(negedge clk);
    n_vec = n_vec + 1;
    if (in_rdy !== 1'b0 || out_valid !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL full_hold: in_rdy=%b out_valid=%b, required 0 1", in_rdy, out_valid);
    end
    @(posedge clk); #1 out_rdy = 1'b1;
    @(posedge clk); #1 out_rdy = 1'b0;
    @(negedge clk);
    n_vec = n_vec + 1;
    if (in_rdy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL full_free1: in_rdy=%b, required 0", in_rdy);
    end
    @(posedge clk); #1 out_rdy = 1'b1;
    @(posedge clk); #1 out_rdy = 1'b0;
    @(negedge clk);
    n_vec = n_vec + 1;
    if (in_rdy !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL full_free2: in_rdy=%b, required 1", in_rdy);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_excp();
    out_rdy = 1'b1;
    push(32'h1c002000, 32'd0, 1'b0, 32'd0, 1'b1, 6'h08);
    drive_group(32'h1c002000, 2'b11, 1'b0, 1'b0, 32'd0, ADDI, ADD, 1'b1, 6'h08, 1'b0);
    @(negedge clk);
    n_vec = n_vec + 1;
    if (in_rdy !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL excp_accept: in_rdy=%b, required 1", in_rdy);
    end
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b1 || out_excp_valid !== 1'b1 || out_excp_ecode !== 6'h08) begin
      n_err = n_err + 1;
      $display("FAIL excp_out: valid=%b ex=%b ec=%h, required 1 1 08", out_valid, out_excp_valid, out_excp_ecode);
    end
    @(posedge clk); #1;
    in_excp_valid = 1'b0; in_excp_ecode = 6'd0;
    drain();
  endtask

  task automatic test_back_to_back();
    out_rdy = 1'b1;
    for (int g = 0; g < 6; g++) begin
      logic [31:0] pc, i0, i1;
      logic [1:0]  mask;
      pc   = 32'h1c003000 + 32'(g) * 32'h10;
      i0   = $urandom;
      i1   = $urandom;
      mask = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      push(pc, i0, 1'b0, 32'd0, 1'b0, 6'd0);
      if (mask[1]) push(pc + 32'd4, i1, 1'b0, 32'd0, 1'b0, 6'd0);
      drive_group(pc, mask, 1'b0, 1'b0, 32'd0, i0, i1, 1'b0, 6'd0, 1'b1);
      wait_accept();
    end
    drain();
  endtask

  task automatic test_flush();
    out_rdy = 1'b0;
    drive_group(32'h1c004000, 2'b11, 1'b0, 1'b0, 32'd0, ADD, ADD, 1'b0, 6'd0, 1'b1);
    wait_accept();
    drive_group(32'h1c004008, 2'b11, 1'b0, 1'b0, 32'd0, ADD, ADD, 1'b0, 6'd0, 1'b1);
    wait_accept();
    drive_group(32'h1c004010, 2'b01, 1'b0, 1'b0, 32'd0, ADD, ADD, 1'b0, 6'd0, 1'b1);
    wait_accept();
    drive_group(32'h1c004018, 2'b11, 1'b1, 1'b0, 32'h1c000100, ADDI, ADD, 1'b0, 6'd0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    n_vec = n_vec + 1;
    if (bp_error_flush !== 1'b0 || wr_pc_valid !== 1'b0 || btb_inv_valid !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL flush_pulse: bp=%b wr=%b inv=%b, required 0 0 0", bp_error_flush, wr_pc_valid, btb_inv_valid);
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b0 || in_rdy !== 1'b1 || bp_error_flush !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL flush_after: out_valid=%b in_rdy=%b bp=%b, required 0 1 0", out_valid, in_rdy, bp_error_flush);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    drive_group(32'h1c005000, 2'b11, 1'b0, 1'b0, 32'd0, ADD, ADD, 1'b0, 6'd0, 1'b1);
    wait_accept();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec = n_vec + 1;
    if (out_valid !== 1'b0 || in_rdy !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL reset_mid: out_valid=%b in_rdy=%b, required 0 1", out_valid, in_rdy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_slot_mask = '0;
    in_is_pred = 1'b0; in_pred_slot = '0; in_btb_pre = '0; in_excp_valid = 1'b0;
    in_excp_ecode = '0; icache_data = '0; icache_data_valid = 1'b0; out_rdy = 1'b0;
    test_reset();
    test_latency();
    test_mispredict();
    test_pred_branch();
    test_full();
    test_excp();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
